payment_validator: RTL and testbench
====================================

PAYMENT_VALIDATOR -- requirements
Module: payment_validator

Interface
REQ-001 Parameter FARE, default 7, is the credit units needed to accept a vehicle (1..63).
REQ-002 Parameter TIMEOUT, default 20, is the clock cycles allowed in COLLECT before rejection (2..255).
REQ-003 Port CLK  input  1  system clock; all logic on rising edge.
REQ-004 Port RST  input  1  reset; synchronous, active-high.
REQ-005 Port DCE  input  1  entry detector; vehicle present at entry barrier.
REQ-006 Port COIN  input  1  single-cycle coin strobe; sampled only when high.
REQ-007 Port COIN_VAL  input  2  denomination: 00=1, 01=2, 10=5, 11=10 units.
REQ-008 Port ACK  input  1  controller acknowledge (driven from the controller's Lok|Lnok).
REQ-009 Port POK  output  1  payment accepted, level, held until ACK.
REQ-010 Port PNOK  output  1  payment rejected, level, held until ACK.
REQ-011 Port CHANGE  output  6  overpayment returned; valid while POK=1, else 0.
REQ-012 Port CREDIT  output  6  current accumulated credit.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, COLLECT, PAID, REJECT, WAIT_CLEAR.
REQ-014 IDLE: DCE=1 -> COLLECT; credit and timer cleared on the same edge.
REQ-015 COLLECT: each sampled COIN SHALL add its value to credit on that edge, saturating at 63.
REQ-016 COLLECT: if credit plus the coin sampled on this edge is >= FARE -> PAID on that edge; POK high from the next cycle.
REQ-017 COLLECT: timer increments each cycle; at timer==TIMEOUT-1 with no completing coin -> REJECT; PNOK high exactly TIMEOUT cycles after COLLECT entry.
REQ-018 A completing coin on the timeout edge SHALL win: the FSM goes to PAID, not REJECT.
REQ-019 COLLECT with DCE=0 (vehicle left) -> IDLE, credit cleared, no POK/PNOK; DCE=0 has priority over coin and timeout.
REQ-020 PAID: POK=1, CHANGE=credit-FARE; ACK=1 -> WAIT_CLEAR; COIN ignored.
REQ-021 REJECT: PNOK=1, CHANGE=0; ACK=1 -> WAIT_CLEAR; COIN ignored.
REQ-022 WAIT_CLEAR: POK=PNOK=0, credit cleared; DCE=0 -> IDLE, which blocks a second session for the same vehicle.
REQ-023 ACK in IDLE, COLLECT or WAIT_CLEAR SHALL be ignored.
REQ-024 POK and PNOK SHALL never be high in the same cycle.
REQ-025 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-026 RST=1 at a rising edge SHALL force IDLE with credit=0 and timer=0, from any state including mid-COLLECT or PAID.
REQ-027 Outputs in the cycle after reset: POK=0, PNOK=0, CHANGE=0, CREDIT=0.
REQ-028 RST SHALL take priority over every other input.

Configuration
REQ-029 Macro PAYMENT_VALIDATOR_CHANGE_EN compiled in: CHANGE is driven per REQ-011/REQ-020.
REQ-030 Macro absent: the change subtractor is omitted; CHANGE is tied to 0; POK behaviour is unchanged (overpayment is accepted and kept).

Structure
REQ-031 A shared package SHALL hold the state enum, the COIN_VAL encoding constants, and the credit width constant (6).
REQ-032 The package SHALL provide a coin-value decode function returning a 6-bit value.
REQ-033 One sub-module, payment_timer, SHALL implement the clearable timeout counter with a terminal-count output.
REQ-034 The top-level SHALL hold the FSM and the credit accumulator.

Verification (FARE=7, TIMEOUT=20)
REQ-035 DCE=1, coins 5 then 2 on cycles 2 and 4 -> POK=1 from cycle 5, CHANGE=0; ACK=1 -> POK=0 next cycle; DCE=0 -> IDLE.
REQ-036 DCE=1, a single coin of 10 -> POK=1, CHANGE=3 (macro set) or CHANGE=0 (macro unset).
REQ-037 DCE=1, one coin of 1 and no further coins -> PNOK=1 exactly 20 cycles after COLLECT entry, POK stays 0; ACK clears PNOK.
REQ-038 Completing coin on the timeout cycle (timer==19) -> POK=1, PNOK never asserted.
REQ-039 RST pulse during COLLECT with CREDIT=5 -> CREDIT=0, IDLE; with DCE still 1 the next edge starts a fresh COLLECT.
REQ-040 Eight coins of 10 -> CREDIT saturates at 63 with no wrap-around; also check DCE held high after ACK produces no second POK.

Source files
------------

// File: rtl/payment_validator_pkg.sv
// payment_validator_pkg: shared state encoding, coin encodings, credit width and coin decode.
package payment_validator_pkg;
    localparam int CREDIT_W = 6;
    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;
    typedef enum logic [2:0] {IDLE, COLLECT, PAID, REJECT, WAIT_CLEAR} state_t;
    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] v);
        return v == COIN_1 ? 6'd1 : v == COIN_2 ? 6'd2 : v == COIN_5 ? 6'd5 : 6'd10;
    endfunction
endpackage

// File: rtl/payment_timer.sv
// payment_timer: clearable free-running counter flagging TIMEOUT-1 as terminal count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : forces the count to zero on the next edge, otherwise it increments
//   tc       : high while the registered count equals TIMEOUT-1
module payment_timer #(
    parameter int TIMEOUT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);
    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : cnt_q + 8'd1;
    always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
    assign tc = cnt_q == TC_VAL;
endmodule

// File: rtl/payment_validator.sv
// payment_validator: toll-barrier payment FSM with saturating credit accumulator.
//   CLK, RST      : clock, synchronous active-high reset
//   DCE           : vehicle present at entry barrier
//   COIN/COIN_VAL : single-cycle coin strobe and its denomination
//   ACK           : controller acknowledge, releases PAID/REJECT
//   POK/PNOK      : registered accept/reject levels
//   CHANGE        : overpayment while POK, only when PAYMENT_VALIDATOR_CHANGE_EN is defined
//   CREDIT        : accumulated credit
module payment_validator
    import payment_validator_pkg::*;
#(
    parameter int FARE    = 7,
    parameter int TIMEOUT = 20
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                DCE,
    input  logic                COIN,
    input  logic [1:0]          COIN_VAL,
    input  logic                ACK,
    output logic                POK,
    output logic                PNOK,
    output logic [CREDIT_W-1:0] CHANGE,
    output logic [CREDIT_W-1:0] CREDIT
);
    localparam logic [CREDIT_W-1:0] FARE_C = CREDIT_W'(FARE);
    state_t state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic pok_q, pok_d, pnok_q, pnok_d;
    logic [CREDIT_W:0] sum;
    logic tc;

    payment_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (CLK),
        .rst (RST),
        .clr (state_q != COLLECT),
        .tc  (tc)
    );

    always_comb begin
        sum = {1'b0, credit_q} + {1'b0, COIN ? coin_value(COIN_VAL) : 6'd0};
        state_d = state_q;
        credit_d = credit_q;
        pok_d = pok_q;
        pnok_d = pnok_q;
        case (state_q)
            IDLE: if (DCE) begin
                state_d = COLLECT;
                credit_d = '0;
            end
            COLLECT: if (!DCE) begin
                state_d = IDLE;
                credit_d = '0;
            end else begin
                credit_d = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
                // a completing coin is checked before the timeout so it wins on the last cycle
                if (sum >= {1'b0, FARE_C}) begin
                    state_d = PAID;
                    pok_d = 1'b1;
                end else if (tc) begin
                    state_d = REJECT;
                    pnok_d = 1'b1;
                end
            end
            PAID, REJECT: if (ACK) begin
                state_d = WAIT_CLEAR;
                credit_d = '0;
                pok_d = 1'b0;
                pnok_d = 1'b0;
            end
            WAIT_CLEAR: begin
                credit_d = '0;
                if (!DCE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            credit_q <= '0;
            pok_q <= 1'b0;
            pnok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            credit_q <= credit_d;
            pok_q <= pok_d;
            pnok_q <= pnok_d;
        end
    end

    assign POK = pok_q;
    assign PNOK = pnok_q;
    assign CREDIT = credit_q;
`ifdef PAYMENT_VALIDATOR_CHANGE_EN
    assign CHANGE = state_q == PAID ? credit_q - FARE_C : '0;
`else
    assign CHANGE = '0;
`endif
endmodule

// File: tb/tb_payment_validator.sv
// tb_payment_validator: directed checks of payment_validator (FARE=7, TIMEOUT=20, plus a FARE=63 saturation instance).
module tb_payment_validator;
    logic CLK, RST, DCE, COIN, ACK;
    logic [1:0] COIN_VAL;
    logic POK, PNOK, POK_S, PNOK_S;
    logic [5:0] CHANGE, CREDIT, CHANGE_S, CREDIT_S;
    int checks, failures;
    int exp_chg;

    payment_validator #(.FARE(7), .TIMEOUT(20)) dut (
        .CLK(CLK), .RST(RST), .DCE(DCE), .COIN(COIN), .COIN_VAL(COIN_VAL), .ACK(ACK),
        .POK(POK), .PNOK(PNOK), .CHANGE(CHANGE), .CREDIT(CREDIT)
    );

    payment_validator #(.FARE(63), .TIMEOUT(20)) dut_sat (
        .CLK(CLK), .RST(RST), .DCE(DCE), .COIN(COIN), .COIN_VAL(COIN_VAL), .ACK(ACK),
        .POK(POK_S), .PNOK(PNOK_S), .CHANGE(CHANGE_S), .CREDIT(CREDIT_S)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic coin(input logic [1:0] v);
        COIN = 1'b1;
        COIN_VAL = v;
        tick();
        COIN = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
`ifdef PAYMENT_VALIDATOR_CHANGE_EN
        exp_chg = 3;
`else
        exp_chg = 0;
`endif
        RST = 1'b1; DCE = 1'b0; COIN = 1'b0; COIN_VAL = 2'b00; ACK = 1'b0;
        tick(2);
        chk("rst_pok", POK, 0);
        chk("rst_pnok", PNOK, 0);
        chk("rst_change", CHANGE, 0);
        chk("rst_credit", CREDIT, 0);
        RST = 1'b0;

        // 5 then 2 with a gap: exact fare
        DCE = 1'b1;
        tick();
        coin(2'b10);
        chk("p5_credit", CREDIT, 5);
        chk("p5_pok", POK, 0);
        tick();
        coin(2'b01);
        chk("p7_pok", POK, 1);
        chk("p7_credit", CREDIT, 7);
        chk("p7_change", CHANGE, 0);
        tick();
        chk("p7_pok_hold", POK, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("p7_ack_pok", POK, 0);
        chk("p7_ack_credit", CREDIT, 0);
        DCE = 1'b0;
        tick(2);
        chk("p7_idle_pok", POK, 0);

        // single 10: overpayment
        DCE = 1'b1;
        tick();
        coin(2'b11);
        chk("p10_pok", POK, 1);
        chk("p10_credit", CREDIT, 10);
        chk("p10_change", CHANGE, exp_chg);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("p10_ack_change", CHANGE, 0);
        DCE = 1'b0;
        tick();

        // one coin of 1 then timeout: PNOK exactly 20 cycles after entry
        DCE = 1'b1;
        tick();
        coin(2'b00);
        chk("to_credit", CREDIT, 1);
        for (int i = 2; i < 20; i++) begin
            tick();
            chk("to_pnok_early", PNOK, 0);
        end
        tick();
        chk("to_pnok", PNOK, 1);
        chk("to_pok", POK, 0);
        chk("to_change", CHANGE, 0);
        tick();
        chk("to_pnok_hold", PNOK, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("to_ack_pnok", PNOK, 0);
        DCE = 1'b0;
        tick();

        // completing coin on the timeout edge wins
        DCE = 1'b1;
        tick();
        tick(19);
        chk("race_pnok_pre", PNOK, 0);
        coin(2'b11);
        chk("race_pok", POK, 1);
        chk("race_pnok", PNOK, 0);
        tick(3);
        chk("race_pnok_later", PNOK, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        DCE = 1'b0;
        tick();

        // reset mid-collect, then fresh session with DCE still high
        DCE = 1'b1;
        tick();
        coin(2'b10);
        chk("mrst_pre_credit", CREDIT, 5);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mrst_credit", CREDIT, 0);
        chk("mrst_pok", POK, 0);
        tick();
        coin(2'b01);
        chk("mrst_fresh_credit", CREDIT, 2);
        chk("mrst_fresh_pok", POK, 0);
        DCE = 1'b0;
        tick();
        chk("leave_credit", CREDIT, 0);
        chk("leave_pok", POK, 0);

        // eight 10s: saturation at 63 on the FARE=63 instance, ignored coins on the main one
        RST = 1'b1;
        tick();
        RST = 1'b0;
        DCE = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            coin(2'b11);
            chk("sat_credit", CREDIT_S, (10 * i > 63) ? 63 : 10 * i);
        end
        chk("sat_pok", POK_S, 1);
        chk("sat_change", CHANGE_S, 0);
        chk("main_credit_held", CREDIT, 10);
        chk("main_pok", POK, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("main_ack_pok", POK, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) coin(2'b11);
            else tick();
            chk("wc_no_pok", POK, 0);
            chk("wc_no_pnok", PNOK, 0);
        end
        chk("wc_credit", CREDIT, 0);
        DCE = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
